// File: rtl/checkpoint_seq_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checkpoint_mon_pkg
// Description : Shared types and default sizing for the checkpoint sequence
//               monitor. Holds the FSM state encoding and default widths.
// Contents    : state_t (IDLE/WAIT/DONE), c_DEFAULT_* sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package checkpoint_mon_pkg;

  localparam int c_DEFAULT_WIDTH   = 16;
  localparam int c_DEFAULT_NUM_CHK = 4;
  localparam int c_DEFAULT_TO_W    = 20;
  localparam int c_DEFAULT_STABLE  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : checkpoint_mon_pkg
`default_nettype wire

// File: rtl/checkpoint_seq_monitor_chk_table.sv
`default_nettype none
// ============================================================================
// Module      : chk_table
// Description : NUM_CHK x WIDTH register file holding the expected checkpoint
//               codes. No reset, so contents survive a monitor reset.
// Ports       : clock             - clock
//               wr_en/wr_idx/wr_data - write port; out-of-range index ignored
//               rd_idx            - read index
//               rd_data           - combinational read data ('0 if out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module chk_table
  import checkpoint_mon_pkg::*;
#(
  parameter int WIDTH   = c_DEFAULT_WIDTH,
  parameter int NUM_CHK = c_DEFAULT_NUM_CHK,
  parameter int IDX_W   = $clog2(NUM_CHK + 1)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [NUM_CHK];

  // Entries are selected by explicit compare so indices >= NUM_CHK match
  // nothing and are silently dropped rather than aliasing onto low entries.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = r_mem[i];
      end
    end
  end

endmodule : chk_table
`default_nettype wire

// File: rtl/checkpoint_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module      : checkpoint_seq_monitor
// Description : Watches a status bus for an ordered sequence of programmed
//               checkpoint codes, each needing STABLE consecutive matching
//               samples, with an optional per-checkpoint timeout.
// Ports       : clock, reset (sync, active-high)
//               start                 - arms a run from IDLE/DONE
//               status_in             - monitored bus
//               exp_wr_en/idx/data    - checkpoint table write (idle only)
//               num_chk               - checkpoints in run (clamped to NUM_CHK)
//               timeout_cycles        - per-checkpoint timeout, 0 = none
//               busy, done, pass, fail_timeout, hit, chk_idx - registered status
// Revision    : 1.0 - initial release
// ============================================================================
module checkpoint_seq_monitor
  import checkpoint_mon_pkg::*;
#(
  parameter int WIDTH   = c_DEFAULT_WIDTH,
  parameter int NUM_CHK = c_DEFAULT_NUM_CHK,
  parameter int IDX_W   = $clog2(NUM_CHK + 1),
  parameter int TO_W    = c_DEFAULT_TO_W,
  parameter int STABLE  = c_DEFAULT_STABLE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] status_in,
  input  logic             exp_wr_en,
  input  logic [IDX_W-1:0] exp_wr_idx,
  input  logic [WIDTH-1:0] exp_wr_data,
  input  logic [IDX_W-1:0] num_chk,
  input  logic [TO_W-1:0]  timeout_cycles,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_timeout,
  output logic             hit,
  output logic [IDX_W-1:0] chk_idx
);

  localparam int SC_W = $clog2(STABLE + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_status_q;
  logic [IDX_W-1:0] r_num;
  logic [TO_W-1:0]  r_timeout;
  logic [TO_W-1:0]  r_timer;
  logic [SC_W-1:0]  r_stable_cnt;

  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic [SC_W-1:0]  w_cnt_inc;
  logic             w_stable_hit;
  logic             w_last;
  logic [IDX_W-1:0] w_num_clamped;
  logic             w_tbl_wr;

  // busy is a registered copy of the WAIT state, so it gates writes cleanly.
  assign w_tbl_wr = exp_wr_en && !busy;

  chk_table #(
    .WIDTH   (WIDTH),
    .NUM_CHK (NUM_CHK),
    .IDX_W   (IDX_W)
  ) u_chk_table (
    .clock   (clock),
    .wr_en   (w_tbl_wr),
    .wr_idx  (exp_wr_idx),
    .wr_data (exp_wr_data),
    .rd_idx  (chk_idx),
    .rd_data (w_exp)
  );

  assign w_match       = (r_status_q == w_exp);
  assign w_cnt_inc     = r_stable_cnt + SC_W'(1);
  assign w_stable_hit  = w_match && (w_cnt_inc == SC_W'(STABLE));
  assign w_last        = (chk_idx == (r_num - IDX_W'(1)));
  assign w_num_clamped = (num_chk > IDX_W'(NUM_CHK)) ? IDX_W'(NUM_CHK) : num_chk;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_status_q   <= '0;
      r_num        <= '0;
      r_timeout    <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_timeout <= 1'b0;
      hit          <= 1'b0;
      chk_idx      <= '0;
    end else begin
      r_status_q <= status_in;
      hit        <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num        <= w_num_clamped;
            r_timeout    <= timeout_cycles;
            r_timer      <= '0;
            r_stable_cnt <= '0;
            chk_idx      <= '0;
            fail_timeout <= 1'b0;
            if (w_num_clamped == '0) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              r_state <= WAIT;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end
        WAIT: begin
          // Completion is evaluated first so it wins over a same-cycle timeout.
          if (w_stable_hit) begin
            hit          <= 1'b1;
            r_stable_cnt <= '0;
            r_timer      <= '0;
            if (w_last) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              chk_idx <= chk_idx + IDX_W'(1);
            end
          end else begin
            r_stable_cnt <= w_match ? w_cnt_inc : '0;
            if ((r_timeout != '0) && (r_timer == r_timeout)) begin
              r_state      <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              fail_timeout <= 1'b1;
            end else if (r_timer != '1) begin
              r_timer <= r_timer + TO_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : checkpoint_seq_monitor
`default_nettype wire

// File: tb/tb_checkpoint_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_checkpoint_seq_monitor
// Description : Scoreboard bench for checkpoint_seq_monitor. Stimulus pushes
//               expected hit/done events with hand-computed cycle stamps; a
//               negedge monitor pops and compares each event the DUT shows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checkpoint_seq_monitor;

  localparam int WIDTH   = 16;
  localparam int NUM_CHK = 4;
  localparam int IDX_W   = 3;
  localparam int TO_W    = 20;
  localparam int STABLE  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] status_in = '0;
  logic             exp_wr_en = 1'b0;
  logic [IDX_W-1:0] exp_wr_idx = '0;
  logic [WIDTH-1:0] exp_wr_data = '0;
  logic [IDX_W-1:0] num_chk = '0;
  logic [TO_W-1:0]  timeout_cycles = '0;
  logic             busy, done, pass, fail_timeout, hit;
  logic [IDX_W-1:0] chk_idx;

  checkpoint_seq_monitor #(
    .WIDTH   (WIDTH),
    .NUM_CHK (NUM_CHK),
    .IDX_W   (IDX_W),
    .TO_W    (TO_W),
    .STABLE  (STABLE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .status_in      (status_in),
    .exp_wr_en      (exp_wr_en),
    .exp_wr_idx     (exp_wr_idx),
    .exp_wr_data    (exp_wr_data),
    .num_chk        (num_chk),
    .timeout_cycles (timeout_cycles),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_timeout   (fail_timeout),
    .hit            (hit),
    .chk_idx        (chk_idx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = hit pulse, 1 = done rising
    int cyc;
    int idx;
    int pass;
    int fail;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic exp_hit(input int c, input int idx);
    ev_t e;
    e.kind = 0; e.cyc = c; e.idx = idx; e.pass = 0; e.fail = 0;
    sb.push_back(e);
  endtask

  task automatic exp_done(input int c, input int idx, input int p, input int f);
    ev_t e;
    e.kind = 1; e.cyc = c; e.idx = idx; e.pass = p; e.fail = f;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_chk_idx", int'(chk_idx), e.idx);
      if (kind == 1) begin
        chk("done_pass", int'(pass), e.pass);
        chk("done_fail_timeout", int'(fail_timeout), e.fail);
        chk("done_busy", int'(busy), 0);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (hit) check_ev(0);
      if (done && !prev_done) check_ev(1);
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input int idx, input logic [WIDTH-1:0] data);
    exp_wr_idx  = IDX_W'(idx);
    exp_wr_data = data;
    exp_wr_en   = 1'b1;
    tick(1);
    exp_wr_en   = 1'b0;
  endtask

  task automatic run(input int n, input int to);
    num_chk        = IDX_W'(n);
    timeout_cycles = TO_W'(to);
    start          = 1'b1;
    tick(1);
    start          = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL event_wait: %0d events still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail_timeout"}, int'(fail_timeout), 0);
    chk({tag, "_hit"}, int'(hit), 0);
    chk({tag, "_chk_idx"}, int'(chk_idx), 0);
  endtask

  int n0;

  initial begin
    // Reset state
    reset = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(1);

    // Table: index 3 repeats index 2's code
    wr(0, 16'hAB40);
    wr(1, 16'hAB51);
    wr(2, 16'hAB62);
    wr(3, 16'hAB62);
    tick(1);

    // num_chk = 0: done/pass one cycle after start
    n0 = cyc;
    exp_done(n0 + 1, 0, 1, 0);
    run(0, 100);
    wait_empty(20);

    // Basic two-checkpoint pass
    n0 = cyc;
    status_in = 16'hAB40;
    exp_hit(n0 + 3, 1);
    exp_hit(n0 + 8, 1);
    exp_done(n0 + 8, 1, 1, 0);
    run(2, 1000);
    tick(4);
    status_in = 16'hAB51;
    wait_empty(50);

    // Glitch rejection: one-cycle AB40, a gap, then held AB40
    n0 = cyc;
    status_in = 16'hAB40;
    exp_hit(n0 + 5, 0);
    exp_done(n0 + 5, 0, 1, 0);
    run(1, 0);
    status_in = 16'h0000;
    tick(1);
    status_in = 16'hAB40;
    wait_empty(50);

    // Timeout: AB40 hit, AB51 never shows, done 51 cycles after the hit
    n0 = cyc;
    exp_hit(n0 + 3, 1);
    exp_done(n0 + 54, 1, 0, 1);
    run(2, 50);
    wait_empty(200);

    // Tie: final match completes on the cycle the timer hits the limit
    status_in = 16'h0000;
    tick(2);
    n0 = cyc;
    exp_hit(n0 + 7, 0);
    exp_done(n0 + 7, 0, 1, 0);
    run(1, 5);
    tick(3);
    status_in = 16'hAB40;
    wait_empty(50);

    // num_chk clamp (7 -> 4) and a repeated code in consecutive checkpoints
    n0 = cyc;
    status_in = 16'hAB40;
    exp_hit(n0 + 3, 1);
    exp_hit(n0 + 8, 2);
    exp_hit(n0 + 13, 3);
    exp_hit(n0 + 15, 3);
    exp_done(n0 + 15, 3, 1, 0);
    run(7, 100);
    tick(4);
    status_in = 16'hAB51;
    tick(5);
    status_in = 16'hAB62;
    wait_empty(100);

    // timeout = 0: stays busy; table writes while busy are dropped
    n0 = cyc;
    status_in = 16'hAB40;
    exp_hit(n0 + 3, 1);
    run(2, 0);
    tick(5);
    wr(0, 16'h1234);
    wr(1, 16'h1234);
    tick(3000);
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_done", int'(done), 0);
    chk("no_timeout_chk_idx", int'(chk_idx), 1);
    wait_empty(1);

    // Reset mid-run at chk_idx = 1
    reset = 1'b1;
    tick(1);
    check_all_zero("midrun_reset");
    reset = 1'b0;
    tick(1);

    // Out-of-range writes must not alias onto live entries
    wr(4, 16'h1234);
    wr(7, 16'h1234);
    status_in = 16'h0000;
    tick(2);

    // Rerun with the retained table
    n0 = cyc;
    status_in = 16'hAB40;
    exp_hit(n0 + 3, 1);
    exp_hit(n0 + 8, 1);
    exp_done(n0 + 8, 1, 1, 0);
    run(2, 100);
    tick(4);
    status_in = 16'hAB51;
    wait_empty(50);

    tick(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_checkpoint_seq_monitor
`default_nettype wire
